// File: rtl/inpkt_parser_v3.sv
// inpkt_parser_v3: receive-side packet parser. Consumes 16-bit words of the
// host byte stream, validates the 10-byte header and both checksums, and
// streams data words with packet attributes to the packet handler.
`ifndef PKT_COMM_VERSION
`define PKT_COMM_VERSION 8'h02
`endif

module inpkt_parser_v3 #(
  parameter logic [7:0] VERSION      = `PKT_COMM_VERSION,
  parameter int         PKT_MAX_TYPE = 7,
  parameter int         DATA_MAX_LEN = 16384
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_rd_en,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic        pkt_new,
  output logic        pkt_end,
  output logic        pkt_done,
  output logic        err,
  output logic [2:0]  err_code
);

  // data word counter covers 0 .. DATA_MAX_LEN/2-1
  localparam int CW = (DATA_MAX_LEN > 2) ? $clog2(DATA_MAX_LEN / 2) : 1;

  localparam logic [2:0] E_VER  = 3'd1;
  localparam logic [2:0] E_TYPE = 3'd2;
  localparam logic [2:0] E_LEN  = 3'd3;
  localparam logic [2:0] E_HCK  = 3'd4;
  localparam logic [2:0] E_DCK  = 3'd5;

  typedef enum logic [2:0] {HDR, HCK0, HCK1, DATA, DCK0, DCK1, ERROR} state_t;

  state_t         state;
  logic [2:0]     hcnt;
  logic [CW-1:0]  dcnt;
  logic [31:0]    sum;
  logic [15:0]    ck_lo;
  logic [15:0]    len_lo;
  logic [7:0]     type_hold;

  logic           accept;
  logic           pos_odd;
  logic [31:0]    sum_add;
  logic           last_word;
  logic           ver_bad;
  logic           type_bad;
  logic           len_bad;
  logic           ck_ok;

  // Only data words can stall: a pending dout the consumer is not taking
  // blocks the next data word. ERROR blocks everything until reset.
  assign full = (state == ERROR) ||
                ((state == DATA) && dout_valid && !dout_rd_en);

  assign accept    = wr_en && !full;
  assign pos_odd   = (state == HDR) ? hcnt[0] : dcnt[0];
  assign sum_add   = pos_odd ? {din, 16'h0} : {16'h0, din};
  assign last_word = (16'(dcnt) == ({1'b0, len_lo[15:1]} - 16'd1));
  assign ver_bad   = (din[7:0] != VERSION);
  assign type_bad  = (din[15:8] == 8'd0) ||
                     ({24'h0, din[15:8]} > 32'(PKT_MAX_TYPE));
  // evaluated while din carries len[31:16]
  assign len_bad   = (len_lo == 16'd0) || len_lo[0] ||
                     ({16'h0, len_lo} > 32'(DATA_MAX_LEN)) || (din != 16'd0);
  // checksum words arrive low half first; din is the high half here
  assign ck_ok     = ({din, ck_lo} == ~sum);

  // Parser FSM, checksum accumulation and the registered output stage
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= HDR;
      hcnt       <= '0;
      dcnt       <= '0;
      sum        <= '0;
      ck_lo      <= '0;
      len_lo     <= '0;
      type_hold  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pkt_new    <= 1'b0;
      pkt_end    <= 1'b0;
      pkt_done   <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      pkt_type   <= '0;
      pkt_id     <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (dout_valid && dout_rd_en) begin
        dout_valid <= 1'b0;
        pkt_new    <= 1'b0;
        pkt_end    <= 1'b0;
      end
      if (accept) begin
        case (state)
          HDR: begin
            sum <= sum + sum_add;
            if (hcnt == 3'd4) begin
              hcnt  <= '0;
              state <= HCK0;
            end else begin
              hcnt <= hcnt + 3'd1;
            end
            // error checks come last so their state write wins
            case (hcnt)
              3'd0: begin
                type_hold <= din[15:8];
                if (ver_bad) begin
                  state <= ERROR; err <= 1'b1; err_code <= E_VER;
                end else if (type_bad) begin
                  state <= ERROR; err <= 1'b1; err_code <= E_TYPE;
                end
              end
              3'd2: len_lo <= din;
              3'd3: if (len_bad) begin
                state <= ERROR; err <= 1'b1; err_code <= E_LEN;
              end
              3'd4: begin
                pkt_id   <= din;
                pkt_type <= type_hold;
              end
              default: ;
            endcase
          end
          HCK0: begin
            ck_lo <= din;
            state <= HCK1;
          end
          HCK1: begin
            if (ck_ok) begin
              sum   <= '0;
              dcnt  <= '0;
              state <= DATA;
            end else begin
              state <= ERROR; err <= 1'b1; err_code <= E_HCK;
            end
          end
          DATA: begin
            sum        <= sum + sum_add;
            dout       <= din;
            dout_valid <= 1'b1;
            pkt_new    <= (dcnt == '0);
            pkt_end    <= last_word;
            if (last_word) state <= DCK0;
            else           dcnt  <= dcnt + 1'b1;
          end
          DCK0: begin
            ck_lo <= din;
            state <= DCK1;
          end
          DCK1: begin
            if (ck_ok) begin
              pkt_done <= 1'b1;
              sum      <= '0;
              hcnt     <= '0;
              state    <= HDR;
            end else begin
              state <= ERROR; err <= 1'b1; err_code <= E_DCK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inpkt_parser_v3.sv
// Scoreboard bench for inpkt_parser_v3: directed packets with hand-computed
// checksums; expected data words and done/error events are queued by the
// stimulus and checked by an independent monitor.
module tb_inpkt_parser_v3;

  logic        CLK = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        wr_en;
  logic        full;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_rd_en;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic        pkt_new;
  logic        pkt_end;
  logic        pkt_done;
  logic        err;
  logic [2:0]  err_code;

  inpkt_parser_v3 dut (
    .CLK(CLK), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .dout(dout), .dout_valid(dout_valid), .dout_rd_en(dout_rd_en),
    .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_new(pkt_new),
    .pkt_end(pkt_end), .pkt_done(pkt_done), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic        n;
    logic        e;
  } dexp_t;

  dexp_t      dq[$];
  logic [2:0] eq[$];   // 0 = pkt_done pulse, otherwise error code
  int         nvec = 0;
  int         nfail = 0;
  logic       err_q = 1'b0;
  logic       watch_full = 1'b0;
  int         full_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares every DUT output event against the scoreboard queues
  always @(negedge CLK) begin
    if (!rst) begin
      if (dout_valid && dout_rd_en) begin
        if (dq.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL dout_unexpected: got %h with no word expected", dout);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          chk("dout", {14'h0, pkt_new, pkt_end, dout}, {14'h0, e.n, e.e, e.d});
        end
      end
      if (pkt_done) begin
        if (eq.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL pkt_done_unexpected: got pulse expected none");
        end else chk("pkt_done_event", 32'(0), 32'(eq.pop_front()));
      end
      if (err && !err_q) begin
        if (eq.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL err_unexpected: got code %0d expected no error", err_code);
        end else chk("err_code", 32'(err_code), 32'(eq.pop_front()));
      end
      if (watch_full && full) full_cnt++;
    end
    err_q = err;
  end

  task automatic send(input logic [15:0] w);
    int t;
    bit f;
    din   = w;
    wr_en = 1'b1;
    t     = 0;
    do begin
      @(negedge CLK);
      f = full;
      @(posedge CLK);
      #1;
      t++;
    end while (f && t < 40);
    if (f) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: word %h not accepted, full=1 expected 0", w);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((dq.size() != 0 || eq.size() != 0) && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk("drain_pending", 32'(dq.size() + eq.size()), 32'(0));
  endtask

  task automatic chk_reset();
    chk("rst_full",     32'(full),       32'(0));
    chk("rst_dout",     32'(dout),       32'(0));
    chk("rst_valid",    32'(dout_valid), 32'(0));
    chk("rst_new_end",  32'({pkt_new, pkt_end}), 32'(0));
    chk("rst_done",     32'(pkt_done),   32'(0));
    chk("rst_err",      32'({err, err_code}), 32'(0));
    chk("rst_type_id",  32'({pkt_type, pkt_id}), 32'(0));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge CLK);
    chk_reset();
    @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  // header W0..W4 + checksum of packet A (id 1234, data AAAA 5555)
  task automatic send_pkt_a();
    dq.push_back('{d: 16'hAAAA, n: 1'b1, e: 1'b0});
    dq.push_back('{d: 16'h5555, n: 1'b0, e: 1'b1});
    eq.push_back(3'd0);
    send(16'h0102); send(16'h35B9); send(16'h0004); send(16'h0000);
    send(16'h1234); send(16'hECC5); send(16'hCA46);
    send(16'hAAAA); send(16'h5555); send(16'h5555); send(16'hAAAA);
  endtask

  // packet B: id 5678, data 1234 5678
  task automatic send_pkt_b();
    dq.push_back('{d: 16'h1234, n: 1'b1, e: 1'b0});
    dq.push_back('{d: 16'h5678, n: 1'b0, e: 1'b1});
    eq.push_back(3'd0);
    send(16'h0102); send(16'h35B9); send(16'h0004); send(16'h0000);
    send(16'h5678); send(16'hA881); send(16'hCA46);
    send(16'h1234); send(16'h5678); send(16'hEDCB); send(16'hA987);
  endtask

  task automatic err_after(input logic [2:0] code);
    idle();
    @(negedge CLK);
    chk("err_flag", 32'({err, full}), 32'(2'b11));
    chk("err_no_dout", 32'(dout_valid), 32'(0));
    drain();
    repeat (3) @(posedge CLK);
    #1;
    chk("err_sticky", 32'({err, full, err_code}), 32'({2'b11, code}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    din        = '0;
    dout_rd_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset();
    rst = 1'b0;

    // single valid packet
    send_pkt_a();
    idle();
    drain();
    chk("pkt_type", 32'(pkt_type), 32'h01);
    chk("pkt_id",   32'(pkt_id),   32'h1234);
    chk("no_err",   32'(err),      32'(0));

    // back-to-back, wr_en held high throughout
    watch_full = 1'b1;
    send_pkt_a();
    send_pkt_b();
    idle();
    watch_full = 1'b0;
    drain();
    chk("b2b_full_never", 32'(full_cnt), 32'(0));
    chk("b2b_pkt_id", 32'(pkt_id), 32'h5678);

    // backpressure: consumer stalls 5 cycles during data
    dq.push_back('{d: 16'hAAAA, n: 1'b1, e: 1'b0});
    dq.push_back('{d: 16'h5555, n: 1'b0, e: 1'b1});
    eq.push_back(3'd0);
    send(16'h0102); send(16'h35B9); send(16'h0004); send(16'h0000);
    send(16'h1234); send(16'hECC5); send(16'hCA46);
    dout_rd_en = 1'b0;
    fork
      begin
        send(16'hAAAA); send(16'h5555); send(16'h5555); send(16'hAAAA);
      end
      begin
        repeat (3) @(negedge CLK);
        chk("bp_full", 32'({full, dout_valid}), 32'(2'b11));
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        dout_rd_en = 1'b1;
      end
    join
    idle();
    drain();

    // header checksum corrupted
    eq.push_back(3'd4);
    send(16'h0102); send(16'h35B9); send(16'h0004); send(16'h0000);
    send(16'h1234); send(16'hECC4); send(16'hCA46);
    err_after(3'd4);
    do_reset();

    // odd length
    eq.push_back(3'd3);
    send(16'h0102); send(16'h35B9); send(16'h0003); send(16'h0000);
    err_after(3'd3);
    do_reset();

    // bad version
    eq.push_back(3'd1);
    send(16'h0103);
    err_after(3'd1);
    do_reset();

    // type zero
    eq.push_back(3'd2);
    send(16'h0002);
    err_after(3'd2);
    do_reset();

    // reset mid-packet, then a full valid packet
    send(16'h0102); send(16'h35B9); send(16'h0004);
    do_reset();
    send_pkt_a();
    idle();
    drain();
    chk("post_rst_type_id", 32'({pkt_type, pkt_id}), 32'h00011234);
    chk("post_rst_err", 32'({err, full}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
